parity_check_arbiter: RTL and testbench
=======================================

# parity_check_arbiter

Shares a single odd-parity checking stage between NREQ requesters, each presenting a DW-bit data word plus a parity bit. A round-robin arbiter grants one requester per cycle and captures its word. The registered check result comes back one cycle later, tagged with the requester ID. The block keeps a saturating per-requester parity-error counter and sits between the parity-protected sources and the error-reporting logic.

## Interface
- NREQ, 4, number of requesters (≥2)
- DW, 4, data width per requester
- CW, 8, width of each error counter
- clk  input  1  system clock, rising edge
- rst  input  1  reset; asynchronous and active-high
- req  input  NREQ  per-requester request; held until granted
- data  input  NREQ*DW  requester i word at bits [i*DW +: DW]
- pb  input  NREQ  per-requester odd-parity bit
- clr_cnt  input  1  synchronous clear of all error counters
- gnt  output  NREQ  one-hot grant, combinational; the word is accepted at the clock edge ending a cycle with gnt[i]=1
- rsp_valid  output  1  result valid, one-cycle pulse
- rsp_id  output  clog2(NREQ)  index of the requester for the current result
- rsp_error  output  1  1 = parity error; valid only when rsp_valid=1
- err_cnt  output  NREQ*CW  counter i at bits [i*CW +: CW]

## Operation
- **Parity rule.**
  - Error = ~((^word) ^ pb_bit).
  - The total count of ones across the word and the parity bit must be odd; an even total flags an error.
- **Arbitration.**
  - Internal pointer ptr (clog2(NREQ) bits) has reset value 0.
  - Each cycle, the winner is the first i with req[i]=1, searching ptr, ptr+1, … with wrap modulo NREQ.
  - gnt is set to one-hot of the winner. If no req is high, gnt=0.
- **Pointer update.**
  - On a grant to i, ptr becomes (i+1) mod NREQ.
  - With no grant, ptr holds its value.
- **Capture.**
  - At the edge ending a granted cycle, the winner's word, pb and index are registered.
  - The result register then loads rsp_error and rsp_id, and rsp_valid=1 for exactly the following cycle.
  - If the following cycle also grants, rsp_valid stays high continuously, giving a throughput of 1 result per cycle.
- **Counters.**
  - On the edge where rsp_valid=1 and rsp_error=1, err_cnt[rsp_id] increments.
  - Counters saturate at 2^CW−1 and never wrap.
- **Clear.**
  - clr_cnt=1 zeroes all counters at the next edge.
  - clr_cnt takes priority over a simultaneous increment, including one on the same counter.
- **Requester duty.** A requester deasserts or changes req, data and pb only after an edge at which its gnt was 1.
- **Reset.**
  - Asserting rst forces gnt=0 immediately, and gnt stays 0 while rst=1.
  - Reset also clears, with no clock needed: rsp_valid=0, rsp_id=0, rsp_error=0, all err_cnt=0, ptr=0.
  - Any in-flight result is dropped and never reported.

## Timing
- gnt is combinational from req and ptr within the same cycle.
- Latency: grant in cycle N gives rsp_valid, rsp_id and rsp_error in cycle N+1.
- err_cnt update is visible in cycle N+2.
- With every req held high, the grant order is ptr, ptr+1, …, one per cycle; starvation is bounded to NREQ−1 cycles.
- The first rising edge after rst deasserts acts as a normal cycle. Arbitration starts from ptr=0.
- A req that rises in the same cycle as another request is arbitrated immediately in that cycle.

## Test plan
1. **Reset.** Apply rst=1 with req=4'b1111 and toggle clk → gnt=0, rsp_valid=0, rsp_id=0, rsp_error=0, err_cnt=0. The first grant after release goes to gnt=4'b0001.
2. **Single requester, no error.** req=4'b0010, data[7:4]=4'b0001, pb[1]=0 → gnt=4'b0010 in the same cycle. Next cycle: rsp_valid=1, rsp_id=1, rsp_error=0. Then apply data[7:4]=4'b1010 with pb[1]=0 → rsp_error=1, and err_cnt[1]=1 one cycle after that.
3. **Round-robin fairness.** Hold req=4'b1111 from ptr=0 → gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, and rsp_id sequence 0, 1, 2, 3, 0 lagging by one cycle. Separately, with req=4'b1001 and ptr=1 → gnt=1000, then 0001.
4. **Saturation.** Set CW=2 and give requester 0 five consecutive error words (data=4'b0000, pb=0) → err_cnt[0] reads 1, 2, 3, 3, 3, with no other counter changing.
5. **Clear priority.** Issue clr_cnt=1 in the same cycle as rsp_valid=1, rsp_error=1, rsp_id=2, with err_cnt[2]=5 → err_cnt[2]=0 next cycle, not 1.
6. **Reset mid-operation.** Assert rst during the cycle after a grant, while rsp_valid=1 → rsp_valid drops to 0 immediately and no counter increments. After release with req=4'b0100, the grant is 4'b0100 and the result appears normally one cycle later.

Source files
------------

// File: rtl/parity_check_arbiter_if.sv
`default_nettype none
// ============================================================================
// parity_check_arbiter_if : requester/result bundle for parity_check_arbiter
// Revision: 1.0
// ============================================================================
interface parity_check_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 4,
    parameter int CW   = 8
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] data;
    logic [NREQ-1:0]    pb;
    logic               clr_cnt;
    logic [NREQ-1:0]    gnt;
    logic               rsp_valid;
    logic [IW-1:0]      rsp_id;
    logic               rsp_error;
    logic [NREQ*CW-1:0] err_cnt;

    modport master (
        output req, data, pb, clr_cnt,
        input  gnt, rsp_valid, rsp_id, rsp_error, err_cnt
    );

    modport slave (
        input  req, data, pb, clr_cnt,
        output gnt, rsp_valid, rsp_id, rsp_error, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/parity_check_arbiter.sv
`default_nettype none
// ============================================================================
// parity_check_arbiter : round-robin shared odd-parity checker with
//                        saturating per-requester error counters
// Revision: 1.0
// ============================================================================
module parity_check_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 4,
    parameter int CW   = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    parity_check_arbiter_if.slave bus
);
    localparam int            IW      = $clog2(NREQ);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [IW-1:0]   ptr;
    logic [IW-1:0]   win_idx;
    logic            win_any;
    logic [DW-1:0]   win_word;
    logic            win_pb;
    logic [NREQ-1:0] gnt_vec;
    logic            res_valid;
    logic [IW-1:0]   res_id;
    logic            res_error;
    logic [CW-1:0]   cnt [NREQ];

    // Scan the search order backwards so the earliest candidate after ptr wins.
    always_comb begin
        int unsigned cand;
        win_any = 1'b0;
        win_idx = ptr;
        cand    = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = (int'(ptr) + k) % NREQ;
            if (bus.req[cand]) begin
                win_any = 1'b1;
                win_idx = IW'(cand);
            end
        end
    end

    always_comb begin
        win_word = bus.data[int'(win_idx)*DW +: DW];
        win_pb   = bus.pb[win_idx];
    end

    always_comb begin
        gnt_vec = '0;
        if (!rst && win_any) begin
            gnt_vec[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_error <= 1'b0;
        end else begin
            res_valid <= win_any;
            if (win_any) begin
                ptr       <= IW'((int'(win_idx) + 1) % NREQ);
                res_id    <= win_idx;
                res_error <= ~((^win_word) ^ win_pb);
            end
        end
    end

    // Clear outranks a coincident increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                cnt[i] <= '0;
            end
        end else if (bus.clr_cnt) begin
            for (int i = 0; i < NREQ; i++) begin
                cnt[i] <= '0;
            end
        end else if (res_valid && res_error && (cnt[res_id] != CNT_MAX)) begin
            cnt[res_id] <= cnt[res_id] + CW'(1);
        end
    end

    assign bus.gnt       = gnt_vec;
    assign bus.rsp_valid = res_valid;
    assign bus.rsp_id    = res_id;
    assign bus.rsp_error = res_error;

    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_err_cnt
            assign bus.err_cnt[i*CW +: CW] = cnt[i];
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_parity_check_arbiter.sv
`default_nettype none
// ============================================================================
// tb_parity_check_arbiter : scoreboard bench for parity_check_arbiter
// Revision: 1.0
// ============================================================================
module tb_parity_check_arbiter;
    logic clk;
    logic rst;

    parity_check_arbiter_if #(.NREQ(4), .DW(4), .CW(8)) bus1 ();
    parity_check_arbiter_if #(.NREQ(4), .DW(4), .CW(2)) bus2 ();

    parity_check_arbiter #(.NREQ(4), .DW(4), .CW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    parity_check_arbiter #(.NREQ(4), .DW(4), .CW(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int tests = 0;
    int fails = 0;
    logic [2:0] exp_q [$];
    logic [2:0] e;

    logic [3:0] rr_gnt [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    logic [1:0] rr_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] sat    [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Checks gnt mid-cycle, optionally queues the expected result, then advances one cycle.
    task automatic step(input logic [3:0] eg, input logic [1:0] id, input logic err, input bit push);
        #3;
        check("gnt", 32'(bus1.gnt), 32'(eg));
        if (push) exp_q.push_back({id, err});
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (bus1.rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 rsp_id=%0d, expected no result", bus1.rsp_id);
            end else begin
                e = exp_q.pop_front();
                check("rsp_id", 32'(bus1.rsp_id), 32'(e[2:1]));
                check("rsp_error", 32'(bus1.rsp_error), 32'(e[0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b1;
        bus1.req     = 4'hF;
        bus1.data    = 16'h0000;
        bus1.pb      = 4'hF;
        bus1.clr_cnt = 1'b0;
        bus2.req     = 4'h0;
        bus2.data    = 16'h0000;
        bus2.pb      = 4'h0;
        bus2.clr_cnt = 1'b0;

        // Reset state with all requests high
        repeat (3) @(posedge clk);
        #1;
        #3;
        check("rst_gnt", 32'(bus1.gnt), 32'h0);
        check("rst_rsp_valid", 32'(bus1.rsp_valid), 32'h0);
        check("rst_rsp_id", 32'(bus1.rsp_id), 32'h0);
        check("rst_rsp_error", 32'(bus1.rsp_error), 32'h0);
        check("rst_err_cnt", bus1.err_cnt, 32'h0);
        check("rst_err_cnt_sat", 32'(bus2.err_cnt), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Round robin with all requests held, starting at ptr=0
        for (int k = 0; k < 5; k++) begin
            step(rr_gnt[k], rr_id[k], 1'b0, 1'b1);
        end

        // ptr=1, req=1001
        bus1.req = 4'b1001;
        step(4'b1000, 2'd3, 1'b0, 1'b1);
        step(4'b0001, 2'd0, 1'b0, 1'b1);

        // Single requester: good word, then bad word
        bus1.req  = 4'b0010;
        bus1.data = 16'h0010;
        bus1.pb   = 4'b1101;
        step(4'b0010, 2'd1, 1'b0, 1'b1);
        bus1.data = 16'h00A0;
        step(4'b0010, 2'd1, 1'b1, 1'b1);
        bus1.req = 4'b0000;
        step(4'b0000, 2'd0, 1'b0, 1'b0);
        #3;
        check("err_cnt_after_err1", bus1.err_cnt, 32'h0000_0100);
        @(posedge clk);
        #1;

        // Five errors on requester 2, then a sixth coinciding with clear
        bus1.req  = 4'b0100;
        bus1.data = 16'h0000;
        bus1.pb   = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            step(4'b0100, 2'd2, 1'b1, 1'b1);
        end
        bus1.req     = 4'b0000;
        bus1.clr_cnt = 1'b1;
        #3;
        check("err_cnt_before_clr", bus1.err_cnt, 32'h0005_0100);
        @(posedge clk);
        #1;
        bus1.clr_cnt = 1'b0;
        check("err_cnt_after_clr", bus1.err_cnt, 32'h0);

        // Reset while a result is being presented
        bus1.req  = 4'b1000;
        bus1.pb   = 4'b0111;
        step(4'b1000, 2'd3, 1'b1, 1'b0);
        bus1.req = 4'b0000;
        check("rsp_valid_pre_rst", 32'(bus1.rsp_valid), 32'h1);
        #1;
        rst       = 1'b1;
        bus1.req  = 4'b0100;
        bus1.data = 16'h0100;
        bus1.pb   = 4'b1011;
        #1;
        check("rsp_valid_async_rst", 32'(bus1.rsp_valid), 32'h0);
        check("gnt_in_rst", 32'(bus1.gnt), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("err_cnt_after_rst", bus1.err_cnt, 32'h0);
        step(4'b0100, 2'd2, 1'b0, 1'b1);
        bus1.req = 4'b0000;
        step(4'b0000, 2'd0, 1'b0, 1'b0);
        step(4'b0000, 2'd0, 1'b0, 1'b0);

        // Saturation on the 2-bit counter instance
        bus2.req = 4'b0001;
        for (int c = 0; c < 7; c++) begin
            if (c == 5) bus2.req = 4'b0000;
            #3;
            if (c >= 2) begin
                check("sat_cnt0", 32'(bus2.err_cnt[1:0]), 32'(sat[c-2]));
                check("sat_others", 32'(bus2.err_cnt[7:2]), 32'h0);
            end
            @(posedge clk);
            #1;
        end

        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
